// File: rtl/instr_sequencer_if.sv
// Memory request/ack bus plus decoder/execute handshake for the 6502 instruction front end.
// Defining SEQ_ILLEGAL_TRAP_EN adds the illegal_op status line.
interface instr_sequencer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [7:0]        opcode;
  logic [7:0]        operand_lo;
  logic [7:0]        operand_hi;
  logic [1:0]        instr_len;
  logic              instr_valid;
  logic              exec_done;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              halted;
  logic [ADDR_W-1:0] pc;
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic              illegal_op;
`endif

  modport master (
    output mem_req, mem_addr, opcode, operand_lo, operand_hi, instr_len, instr_valid,
    output halted, pc,
    input  mem_ack, mem_rdata, exec_done, redirect, redirect_pc, halt
`ifdef SEQ_ILLEGAL_TRAP_EN
    , output illegal_op
`endif
  );

  modport slave (
    input  mem_req, mem_addr, opcode, operand_lo, operand_hi, instr_len, instr_valid,
    input  halted, pc,
    output mem_ack, mem_rdata, exec_done, redirect, redirect_pc, halt
`ifdef SEQ_ILLEGAL_TRAP_EN
    , input illegal_op
`endif
  );
endinterface

// File: rtl/instr_sequencer.sv
// 6502 fetch sequencer: fetches opcode plus 0-2 operands, holds the instruction until execute
// retires it, applies redirects and halts. SEQ_ILLEGAL_TRAP_EN traps illegal opcodes into HALT.
module instr_sequencer #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0200
) (
  input logic               clk,
  input logic               rst_n,
  instr_sequencer_if.master bus
);

  typedef enum logic [2:0] {StFetchOp, StFetchB1, StFetchB2, StExec, StHalt} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              mem_req_q;
  logic [7:0]        opcode_q;
  logic [7:0]        operand_lo_q;
  logic [7:0]        operand_hi_q;
  logic [1:0]        instr_len_q;
  logic              instr_valid_q;
  logic              halted_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [1:0]        len_d;
  logic              xfer;

  // Illegal opcodes decode as length 1.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] cc;
    logic [2:0] bbb;
    cc     = op[1:0];
    bbb    = op[4:2];
    op_len = 2'd1;
    case (cc)
      2'b01: op_len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
      2'b00, 2'b10: begin
        case (bbb)
          3'b001, 3'b101: op_len = 2'd2;
          3'b011, 3'b111: op_len = 2'd3;
          3'b010, 3'b110: op_len = 2'd1;
          3'b100:         op_len = (cc == 2'b00) ? 2'd2 : 2'd1;
          default: begin
            case (op)
              8'h20:                      op_len = 2'd3;
              8'hA0, 8'hA2, 8'hC0, 8'hE0: op_len = 2'd2;
              default:                    op_len = 2'd1;
            endcase
          end
        endcase
      end
      default: op_len = 2'd1;
    endcase
  endfunction

`ifdef SEQ_ILLEGAL_TRAP_EN
  function automatic logic op_illegal(input logic [7:0] op);
    logic [1:0] cc;
    logic [2:0] bbb;
    cc  = op[1:0];
    bbb = op[4:2];
    op_illegal = (cc == 2'b11) || (cc == 2'b10 && bbb == 3'b100) ||
                 (cc != 2'b01 && bbb == 3'b000 &&
                  !(op inside {8'h00, 8'h40, 8'h60, 8'h20, 8'hA0, 8'hA2, 8'hC0, 8'hE0}));
  endfunction

  logic illegal_op_q;
  logic trap;
  assign trap = op_illegal(bus.mem_rdata);
`endif

  assign pc_inc = pc_q + ADDR_W'(1);
  assign len_d  = op_len(bus.mem_rdata);
  assign xfer   = mem_req_q & bus.mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StFetchOp;
      pc_q          <= RESET_PC;
      mem_req_q     <= 1'b0;
      opcode_q      <= 8'h00;
      operand_lo_q  <= 8'h00;
      operand_hi_q  <= 8'h00;
      instr_len_q   <= 2'd1;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
      illegal_op_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StFetchOp: begin
          // Only true on the first cycle out of reset; every other entry raises mem_req itself.
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (xfer) begin
            pc_q         <= pc_inc;
            opcode_q     <= bus.mem_rdata;
            operand_lo_q <= 8'h00;
            operand_hi_q <= 8'h00;
            instr_len_q  <= len_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
            if (trap) begin
              state_q      <= StHalt;
              mem_req_q    <= 1'b0;
              halted_q     <= 1'b1;
              illegal_op_q <= 1'b1;
            end else
`endif
            if (len_d == 2'd1) begin
              state_q       <= StExec;
              mem_req_q     <= 1'b0;
              instr_valid_q <= 1'b1;
            end else begin
              state_q <= StFetchB1;
            end
          end
        end
        StFetchB1: begin
          if (xfer) begin
            pc_q         <= pc_inc;
            operand_lo_q <= bus.mem_rdata;
            if (instr_len_q == 2'd2) begin
              state_q       <= StExec;
              mem_req_q     <= 1'b0;
              instr_valid_q <= 1'b1;
            end else begin
              state_q <= StFetchB2;
            end
          end
        end
        StFetchB2: begin
          if (xfer) begin
            pc_q          <= pc_inc;
            operand_hi_q  <= bus.mem_rdata;
            state_q       <= StExec;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        StExec: begin
          if (bus.exec_done) begin
            instr_valid_q <= 1'b0;
            if (bus.redirect) pc_q <= bus.redirect_pc;
            if (bus.halt) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end else begin
              state_q   <= StFetchOp;
              mem_req_q <= 1'b1;
            end
          end
        end
        StHalt: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
          if (!bus.halt && !illegal_op_q) begin
`else
          if (!bus.halt) begin
`endif
            state_q   <= StFetchOp;
            halted_q  <= 1'b0;
            mem_req_q <= 1'b1;
          end
        end
        default: state_q <= StFetchOp;
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.opcode      = opcode_q;
  assign bus.operand_lo  = operand_lo_q;
  assign bus.operand_hi  = operand_hi_q;
  assign bus.instr_len   = instr_len_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.halted      = halted_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
  assign bus.illegal_op  = illegal_op_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a byte memory with programmable ack delay feeds the DUT,
// directed stimulus queues expected instructions and a monitor checks each one as it issues.
`timescale 1ns/1ps
module tb_instr_sequencer;
  localparam int unsigned ADDR_W = 16;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [1:0]  len;
    logic [15:0] pc;
  } instr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  instr_sequencer #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(16'h0200)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0]  mem [65536];
  int unsigned ack_dly = 0;
  instr_t      exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_dly wait cycles of a held request.
  initial begin
    int unsigned wait_cnt;
    wait_cnt      = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.mem_req && wait_cnt >= ack_dly) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr];
        wait_cnt      = 0;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        wait_cnt      = bus.mem_req ? wait_cnt + 1 : 0;
      end
    end
  end

  // Monitor: each rising instr_valid is checked against the head of the scoreboard.
  initial begin
    logic   prev_valid;
    instr_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_issue: got opcode %0h, expected no instruction", bus.opcode);
        end else begin
          e = exp_q.pop_front();
          check("opcode", bus.opcode, e.op);
          check("operand_lo", bus.operand_lo, e.lo);
          check("operand_hi", bus.operand_hi, e.hi);
          check("instr_len", bus.instr_len, e.len);
          check("issue_pc", bus.pc, e.pc);
        end
      end
      prev_valid = bus.instr_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] lo, input logic [7:0] hi,
                      input logic [1:0] len, input logic [15:0] pc);
    instr_t e;
    e = '{op: op, lo: lo, hi: hi, len: len, pc: pc};
    exp_q.push_back(e);
  endtask

  // Counts request cycles until issue and checks the address never moved while unacked.
  task automatic wait_valid(input string name, input int exp_cycles);
    int          n;
    int          guard;
    int          moved;
    logic        prev_req;
    logic        prev_ack;
    logic [15:0] prev_addr;
    n = 0; guard = 0; moved = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    while (!bus.instr_valid && guard < 200) begin
      if (bus.mem_req) n++;
      if (bus.mem_req && prev_req && !prev_ack && bus.mem_addr !== prev_addr) moved++;
      prev_req  = bus.mem_req;
      prev_ack  = bus.mem_ack;
      prev_addr = bus.mem_addr;
      guard++;
      step();
    end
    if (!bus.instr_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: instr_valid 0 after %0d cycles, expected 1", name, guard);
    end else begin
      check({name, "_cycles"}, n, exp_cycles);
      check({name, "_addr_stable"}, moved, 0);
    end
  endtask

  task automatic retire(input logic redir, input logic [15:0] rpc);
    bus.exec_done   = 1'b1;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    step();
    bus.exec_done = 1'b0;
    bus.redirect  = 1'b0;
  endtask

  initial begin
    int g;
    bus.exec_done   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.halt        = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;
    mem[16'h0202] = 8'h4C; mem[16'h0203] = 8'h34; mem[16'h0204] = 8'h12;
    mem[16'h1234] = 8'h20; mem[16'h1235] = 8'h00; mem[16'h1236] = 8'h03;
    mem[16'hFFFF] = 8'hEA;
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h55; mem[16'h0002] = 8'hEA;
    mem[16'h0003] = 8'h02;

    repeat (3) step();
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h0200);
    check("rst_pc", bus.pc, 16'h0200);
    check("rst_opcode", bus.opcode, 8'h00);
    check("rst_operands", {bus.operand_hi, bus.operand_lo}, 16'h0000);
    check("rst_instr_len", bus.instr_len, 2'd1);
    check("rst_instr_valid", bus.instr_valid, 1'b0);
    check("rst_halted", bus.halted, 1'b0);

    // LDA #$42, zero-wait memory
    push(8'hA9, 8'h42, 8'h00, 2'd2, 16'h0202);
    rst_n = 1'b1;
    step();
    wait_valid("lda_imm", 2);

    // JMP $1234 with redirect
    push(8'h4C, 8'h34, 8'h12, 2'd3, 16'h0205);
    retire(1'b0, 16'h0000);
    wait_valid("jmp_abs", 3);
    ack_dly = 3;
    retire(1'b1, 16'h1234);
    check("redirect_addr", bus.mem_addr, 16'h1234);
    check("redirect_req", bus.mem_req, 1'b1);

    // JSR $0300 with three wait cycles per byte
    push(8'h20, 8'h00, 8'h03, 2'd3, 16'h1237);
    wait_valid("jsr_slow", 12);

    // NOP at $FFFF, pc wraps
    ack_dly = 0;
    push(8'hEA, 8'h00, 8'h00, 2'd1, 16'h0000);
    retire(1'b1, 16'hFFFF);
    check("wrap_addr", bus.mem_addr, 16'hFFFF);
    wait_valid("wrap_nop", 1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h5555;
    step();
    step();
    bus.redirect = 1'b0;
    check("lone_redirect_pc", bus.pc, 16'h0000);
    check("lone_redirect_valid", bus.instr_valid, 1'b1);

    // halt raised while the operand byte is outstanding
    ack_dly = 2;
    push(8'hA9, 8'h55, 8'h00, 2'd2, 16'h0002);
    retire(1'b0, 16'h0000);
    g = 0;
    while (bus.pc != 16'h0001 && g < 50) begin
      step();
      g++;
    end
    check("halt_reach_b1", bus.pc, 16'h0001);
    bus.halt = 1'b1;
    step();
    check("halt_fetch_no_effect", bus.halted, 1'b0);
    wait_valid("halt_mid", 2);
    retire(1'b0, 16'h0000);
    check("halt_halted", bus.halted, 1'b1);
    check("halt_mem_req", bus.mem_req, 1'b0);
    check("halt_valid_drop", bus.instr_valid, 1'b0);
    repeat (3) step();
    check("halt_hold", {bus.halted, bus.mem_req}, 2'b10);
    check("halt_pc", bus.pc, 16'h0002);
    ack_dly = 0;
    push(8'hEA, 8'h00, 8'h00, 2'd1, 16'h0003);
    bus.halt = 1'b0;
    step();
    check("resume_halted", bus.halted, 1'b0);
    check("resume_req", bus.mem_req, 1'b1);
    check("resume_addr", bus.mem_addr, 16'h0002);
    wait_valid("resume", 1);

    // illegal opcode $02
`ifdef SEQ_ILLEGAL_TRAP_EN
    retire(1'b0, 16'h0000);
    repeat (3) step();
    check("trap_illegal_op", bus.illegal_op, 1'b1);
    check("trap_halted", bus.halted, 1'b1);
    check("trap_valid", bus.instr_valid, 1'b0);
    check("trap_mem_req", bus.mem_req, 1'b0);
    check("trap_pc", bus.pc, 16'h0004);
    check("trap_opcode", bus.opcode, 8'h02);
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    repeat (3) step();
    check("trap_sticky", {bus.illegal_op, bus.halted, bus.mem_req}, 3'b110);
`else
    push(8'h02, 8'h00, 8'h00, 2'd1, 16'h0004);
    retire(1'b0, 16'h0000);
    wait_valid("illegal_issue", 1);
    ack_dly = 5;
    retire(1'b0, 16'h0000);
    step();
`endif

    // reset while a request is pending (or while trapped)
    rst_n = 1'b0;
    step();
    check("rst2_mem_req", bus.mem_req, 1'b0);
    check("rst2_pc", bus.pc, 16'h0200);
    check("rst2_state", {bus.instr_valid, bus.halted, bus.instr_len}, 4'b0001);
`ifdef SEQ_ILLEGAL_TRAP_EN
    check("rst2_illegal_op", bus.illegal_op, 1'b0);
`endif
    ack_dly = 5;
    rst_n = 1'b1;
    step();
    check("rst2_restart", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0200});
    check("scoreboard_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
